// File: rtl/uart_pkg.sv
// Shared constants, RX state encoding and elaboration helpers for the UART blocks.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int calc_divisor(input int clock_freq, input int baud, input int oversample);
        return clock_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; a push while full is dropped
// unless a pop frees the slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int EntryWidth = 10,
    parameter int Depth      = 16
) (
    input  logic                  sys_clk_p,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [EntryWidth-1:0] wr_data,
    input  logic                  pop,
    output logic [EntryWidth-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  drop
);

    localparam int AddrW = clog2(Depth);

    logic [EntryWidth-1:0] mem [Depth];
    logic [AddrW:0]        wr_ptr;
    logic [AddrW:0]        rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AddrW] != rd_ptr[AddrW]) && (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Head entry is forced to zero while empty so the outputs read 0 out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr[AddrW-1:0]];

    always_ff @(posedge sys_clk_p or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clk_p) begin
        if (do_push && !clear) mem[wr_ptr[AddrW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver with configurable framing, feeding decoded characters
// and their error flags into a FWFT FIFO, with a saturating overflow counter.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int ClockFreq  = 100_000_000,
    parameter int Baud       = 9600,
    parameter int Oversample = 16,
    parameter int Width      = 8,
    parameter int ParityMode = 0,
    parameter int StopBits   = 1,
    parameter int Depth      = 16,
    parameter int CntWidth   = 16
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                SIn,
    output logic [Width-1:0]    DataOut,
    output logic                ParityErr,
    output logic                FrameErr,
    output logic                DataOutValid,
    input  logic                DataOutReady,
    output logic                Busy,
    output logic [CntWidth-1:0] OverflowCount,
    input  logic                Clear
);

    localparam int Divisor = calc_divisor(ClockFreq, Baud, Oversample);
    localparam int DivW    = clog2(Divisor) + 1;
    localparam int OsW     = clog2(Oversample) + 1;

    localparam logic [DivW-1:0] DivLast  = DivW'(Divisor - 1);
    localparam logic [OsW-1:0]  HalfLast = OsW'(Oversample / 2 - 1);
    localparam logic [OsW-1:0]  FullLast = OsW'(Oversample - 1);
    localparam logic [3:0]      DataLast = 4'(Width - 1);
    localparam logic [3:0]      StopLast = 4'(StopBits - 1);

    if (Divisor < 1) begin : g_bad_divisor
        $error("uart_rx_buffered: ClockFreq too low for Baud*Oversample");
    end

    rx_state_t         state;
    rx_state_t         next_state;
    logic              sin_meta;
    logic              sin_sync;
    logic              sin_prev;
    logic              fall;
    logic [DivW-1:0]   tick_cnt;
    logic              tick;
    logic [OsW-1:0]    os_cnt;
    logic              bit_done;
    logic [3:0]        bit_cnt;
    logic [Width-1:0]  shift;
    logic              par_err;
    logic              frm_err;
    logic              armed;
    logic              enter_start;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;

    assign fall     = sin_prev && !sin_sync;
    assign tick     = (tick_cnt == DivLast);
    assign bit_done = (state != RX_IDLE) && tick &&
                      (os_cnt == ((state == RX_START) ? HalfLast : FullLast));
    assign Busy     = (state != RX_IDLE);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sin_meta <= 1'b1;
            sin_sync <= 1'b1;
            sin_prev <= 1'b1;
        end else begin
            sin_meta <= SIn;
            sin_sync <= sin_meta;
            sin_prev <= sin_sync;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= RX_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state  = state;
        enter_start = 1'b0;
        push        = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall && armed) begin
                    next_state  = RX_START;
                    enter_start = 1'b1;
                end
            end
            RX_START: begin
                if (bit_done) next_state = sin_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (bit_done && bit_cnt == DataLast)
                    next_state = (ParityMode != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (bit_done) next_state = RX_STOP;
            end
            RX_STOP: begin
                if (bit_done && bit_cnt == StopLast) begin
                    next_state = RX_IDLE;
                    push       = 1'b1;
                end
            end
            default: next_state = RX_IDLE;
        endcase
    end

    // A frame that ends with the line low (break) disarms start detection until it idles high.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            armed    <= 1'b1;
        end else begin
            if (enter_start || tick) tick_cnt <= '0;
            else                     tick_cnt <= tick_cnt + 1'b1;

            if (enter_start || bit_done)    os_cnt <= '0;
            else if (tick && state != RX_IDLE) os_cnt <= os_cnt + 1'b1;

            if (next_state != state) bit_cnt <= '0;
            else if (bit_done)       bit_cnt <= bit_cnt + 1'b1;

            if (enter_start) begin
                par_err <= 1'b0;
                frm_err <= 1'b0;
            end
            if (state == RX_DATA && bit_done)
                shift <= {sin_sync, shift[Width-1:1]};
            if (state == RX_PARITY && bit_done)
                par_err <= ((^shift) ^ sin_sync) != (ParityMode == PAR_ODD);
            if (state == RX_STOP && bit_done && !sin_sync)
                frm_err <= 1'b1;

            if (push)                            armed <= sin_sync;
            else if (state == RX_IDLE && sin_sync) armed <= 1'b1;
        end
    end

    uart_rx_fifo #(
        .EntryWidth(Width + 2),
        .Depth     (Depth)
    ) u_fifo (
        .sys_clk_p(Clock),
        .rst_n    (Reset_n),
        .clear    (Clear),
        .push     (push),
        .wr_data  ({par_err, frm_err || !sin_sync, shift}),
        .pop      (DataOutReady),
        .rd_data  ({ParityErr, FrameErr, DataOut}),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    assign DataOutValid = !fifo_empty;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)                                    OverflowCount <= '0;
        else if (Clear)                                  OverflowCount <= '0;
        else if (fifo_drop && fifo_full && OverflowCount != '1) OverflowCount <= OverflowCount + 1'b1;
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench: stimulus queues expected characters, monitors pop and compare on each handshake.
module tb_uart_rx_buffered;

    localparam int BIT     = 16;
    localparam int DEPTH   = 4;
    localparam int OVF_MAX = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a   = 1'b0;
    logic       rst_b   = 1'b0;
    logic       sin_a   = 1'b1;
    logic       sin_b   = 1'b1;
    logic       clear_a = 1'b0;
    logic       clear_b = 1'b0;
    logic       rdy_b   = 1'b1;
    int         mode_a  = 1;
    logic       rnd_a   = 1'b0;
    logic       rdy_a;

    logic [7:0] dout_a;
    logic       pe_a, fe_a, val_a, busy_a;
    logic [1:0] ovf_a;
    logic [6:0] dout_b;
    logic       pe_b, fe_b, val_b, busy_b;
    logic [7:0] ovf_b;

    assign rdy_a = (mode_a == 2) ? rnd_a : (mode_a == 1);

    uart_rx_buffered #(
        .ClockFreq(1_600_000), .Baud(100_000), .Oversample(16), .Width(8),
        .ParityMode(0), .StopBits(1), .Depth(DEPTH), .CntWidth(2)
    ) dut_a (
        .Clock(clk), .Reset_n(rst_a), .SIn(sin_a), .DataOut(dout_a),
        .ParityErr(pe_a), .FrameErr(fe_a), .DataOutValid(val_a),
        .DataOutReady(rdy_a), .Busy(busy_a), .OverflowCount(ovf_a), .Clear(clear_a)
    );

    uart_rx_buffered #(
        .ClockFreq(1_600_000), .Baud(100_000), .Oversample(16), .Width(7),
        .ParityMode(1), .StopBits(2), .Depth(DEPTH), .CntWidth(8)
    ) dut_b (
        .Clock(clk), .Reset_n(rst_b), .SIn(sin_b), .DataOut(dout_b),
        .ParityErr(pe_b), .FrameErr(fe_b), .DataOutValid(val_b),
        .DataOutReady(rdy_b), .Busy(busy_b), .OverflowCount(ovf_b), .Clear(clear_b)
    );

    int         checks    = 0;
    int         failures  = 0;
    int         exp_ovf_a = 0;
    logic [9:0] sb_a [$];
    logic [8:0] sb_b [$];
    logic [9:0] exp_a;
    logic [8:0] exp_b;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        rnd_a = 1'($urandom_range(0, 1));
    end

    // Monitors: every accepted head entry must match the oldest expected character.
    always @(negedge clk) begin
        if (rst_a && val_a && rdy_a) begin
            if (sb_a.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL a_unexpected_entry: got 0x%0h, expected no entry", {pe_a, fe_a, dout_a});
            end else begin
                exp_a = sb_a.pop_front();
                check_output("a_entry", {22'b0, pe_a, fe_a, dout_a}, {22'b0, exp_a});
            end
        end
        if (rst_b && val_b && rdy_b) begin
            if (sb_b.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL b_unexpected_entry: got 0x%0h, expected no entry", {pe_b, fe_b, dout_b});
            end else begin
                exp_b = sb_b.pop_front();
                check_output("b_entry", {23'b0, pe_b, fe_b, dout_b}, {23'b0, exp_b});
            end
        end
    end

    int   run_a = 0;
    int   last_len_a = 0;
    logic val_prev_a = 1'b0;
    logic val_at_fall_a = 1'b0;
    logic val_before_fall_a = 1'b0;

    always @(negedge clk) begin
        if (busy_a) begin
            run_a++;
        end else if (run_a > 0) begin
            last_len_a        = run_a;
            run_a             = 0;
            val_at_fall_a     = val_a;
            val_before_fall_a = val_prev_a;
        end
        val_prev_a = val_a;
    end

    task automatic hold_a(input logic b, input int cycles);
        sin_a = b;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic hold_b(input logic b, input int cycles);
        sin_b = b;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic raw_a(input logic [7:0] d, input logic stop);
        hold_a(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold_a(d[i], BIT);
        hold_a(stop, BIT);
    endtask

    task automatic apply_stimulus_a(input logic [7:0] d, input logic stop, input bit expect_drop);
        if (expect_drop) exp_ovf_a = (exp_ovf_a < OVF_MAX) ? exp_ovf_a + 1 : OVF_MAX;
        else             sb_a.push_back({1'b0, ~stop, d});
        raw_a(d, stop);
    endtask

    // Even parity: the sent parity bit makes the total count of ones even unless corrupted.
    task automatic apply_stimulus_b(input logic [6:0] d, input bit corrupt);
        logic p;
        logic err;
        p   = 1'(($countones(d) % 2) != 0) ^ corrupt;
        err = (($countones(d) + int'(p)) % 2) != 0;
        sb_b.push_back({err, 1'b0, d});
        hold_b(1'b0, BIT);
        for (int i = 0; i < 7; i++) hold_b(d[i], BIT);
        hold_b(p, BIT);
        hold_b(1'b1, 2 * BIT);
    endtask

    task automatic wait_drain_a(input int budget);
        int n = 0;
        while ((sb_a.size() != 0 || val_a) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_output("a_drain", 32'(sb_a.size()) + 32'(val_a), 32'd0);
    endtask

    task automatic wait_drain_b(input int budget);
        int n = 0;
        while ((sb_b.size() != 0 || val_b) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_output("b_drain", 32'(sb_b.size()) + 32'(val_b), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_output("a_reset_outputs", {dout_a, pe_a, fe_a, val_a, busy_a, ovf_a}, 32'd0);
        check_output("b_reset_outputs", {dout_b, pe_b, fe_b, val_b, busy_b, ovf_b}, 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        hold_a(1'b1, 2 * BIT);

        // 8N1 'A' with the consumer always ready.
        mode_a = 1;
        apply_stimulus_a(8'h41, 1'b1, 1'b0);
        hold_a(1'b1, BIT);
        check_output("a_busy_length", 32'(last_len_a), 32'(10 * BIT - 8));
        check_output("a_valid_after_stop", {31'b0, val_at_fall_a}, 32'd1);
        check_output("a_valid_during_stop", {31'b0, val_before_fall_a}, 32'd0);
        wait_drain_a(100);

        // Break: zero frame with low stop bit, line held low.
        apply_stimulus_a(8'h00, 1'b0, 1'b0);
        hold_a(1'b0, 20 * BIT);
        check_output("a_break_idle", {31'b0, busy_a}, 32'd0);
        hold_a(1'b1, 2 * BIT);
        wait_drain_a(100);
        apply_stimulus_a(8'h5A, 1'b1, 1'b0);
        hold_a(1'b1, BIT);
        wait_drain_a(100);

        // Short glitch is a false start.
        hold_a(1'b0, 5);
        hold_a(1'b1, 3 * BIT);
        check_output("a_glitch_busy_length", 32'(last_len_a), 32'd8);
        check_output("a_glitch_no_entry", {31'b0, val_a}, 32'd0);

        // Overflow with the consumer stalled, then saturation.
        mode_a = 0;
        for (int i = 0; i < 6; i++) apply_stimulus_a(8'h30 + 8'(i), 1'b1, sb_a.size() >= DEPTH);
        hold_a(1'b1, BIT);
        check_output("a_overflow_count", {30'b0, ovf_a}, 32'(exp_ovf_a));
        check_output("a_full_valid", {31'b0, val_a}, 32'd1);
        for (int i = 0; i < 2; i++) apply_stimulus_a(8'h36 + 8'(i), 1'b1, sb_a.size() >= DEPTH);
        hold_a(1'b1, BIT);
        check_output("a_overflow_saturate", {30'b0, ovf_a}, 32'(exp_ovf_a));
        mode_a = 1;
        wait_drain_a(50);
        check_output("a_overflow_after_drain", {30'b0, ovf_a}, 32'(exp_ovf_a));
        clear_a = 1'b1;
        @(posedge clk);
        #1;
        clear_a   = 1'b0;
        exp_ovf_a = 0;
        check_output("a_clear_overflow", {30'b0, ovf_a}, 32'd0);

        // Clear flushes held entries.
        mode_a = 0;
        apply_stimulus_a(8'h21, 1'b1, 1'b0);
        apply_stimulus_a(8'h22, 1'b1, 1'b0);
        hold_a(1'b1, BIT);
        clear_a = 1'b1;
        @(posedge clk);
        #1;
        clear_a = 1'b0;
        sb_a.delete();
        check_output("a_clear_flush", {31'b0, val_a}, 32'd0);

        // Full FIFO with a pop in the exact push cycle.
        for (int i = 0; i < 4; i++) apply_stimulus_a(8'h60 + 8'(i), 1'b1, 1'b0);
        check_output("a_prefill_valid", {31'b0, val_a}, 32'd1);
        fork
            apply_stimulus_a(8'h64, 1'b1, 1'b0);
            begin
                repeat (10 * BIT - 6) @(posedge clk);
                #1;
                mode_a = 1;
                @(posedge clk);
                #1;
                mode_a = 0;
            end
        join
        check_output("a_full_push_pop_overflow", {30'b0, ovf_a}, 32'd0);
        mode_a = 1;
        wait_drain_a(50);

        // Reset in the middle of a frame.
        mode_a = 0;
        apply_stimulus_a(8'h11, 1'b1, 1'b0);
        hold_a(1'b1, BIT);
        fork
            raw_a(8'h77, 1'b1);
            begin
                repeat (60) @(posedge clk);
                #1;
                check_output("a_busy_before_reset", {31'b0, busy_a}, 32'd1);
                rst_a = 1'b0;
                sb_a.delete();
                #1;
                check_output("a_reset_mid_frame", {dout_a, pe_a, fe_a, val_a, busy_a, ovf_a}, 32'd0);
            end
        join
        rst_a = 1'b1;
        hold_a(1'b1, 12 * BIT);
        check_output("a_no_entry_after_reset", {31'b0, val_a}, 32'd0);

        // Randomized traffic with a randomly stalling consumer.
        mode_a = 2;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       stop;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            apply_stimulus_a(d, stop, 1'b0);
            if (!stop) hold_a(1'b1, BIT);
            hold_a(1'b1, $urandom_range(0, 2) * BIT);
        end
        mode_a = 1;
        wait_drain_a(200);
        check_output("a_final_overflow", {30'b0, ovf_a}, 32'd0);

        // 7E2: correct parity, corrupted parity, then random.
        apply_stimulus_b(7'h55, 1'b0);
        apply_stimulus_b(7'h55, 1'b1);
        for (int i = 0; i < 12; i++) apply_stimulus_b(7'($urandom), 1'($urandom_range(0, 1)));
        hold_b(1'b1, BIT);
        wait_drain_b(100);
        check_output("b_final_overflow", {24'b0, ovf_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
